// File: rtl/mem_pkg.sv
// Shared encodings for the memory port arbiter: access types, FSM states, owners.
package mem_pkg;

    localparam logic [2:0] DATA_B  = 3'b000;
    localparam logic [2:0] DATA_H  = 3'b001;
    localparam logic [2:0] DATA_W  = 3'b010;
    localparam logic [2:0] DATA_BU = 3'b100;
    localparam logic [2:0] DATA_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StResp
    } mem_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } mem_owner_e;

    function automatic logic sel_legal(input logic [2:0] sel);
        return sel inside {DATA_B, DATA_H, DATA_W, DATA_BU, DATA_HU};
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane steering for stores, load extension and misalignment detection.
module mem_lane_fmt
    import mem_pkg::*;
(
    input  logic [2:0]  sel,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be_mask,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = rdata[{offset, 3'b000} +: 8];
    assign rd_half = rdata[{offset[1], 4'b0000} +: 16];

    always_comb begin
        be_mask    = 4'b0000;
        wdata_lane = wdata;
        rdata_ext  = rdata;
        misalign   = 1'b0;
        unique case (sel)
            DATA_B: begin
                be_mask    = 4'b0001 << offset;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{rd_byte[7]}}, rd_byte};
            end
            DATA_BU: begin
                be_mask    = 4'b0001 << offset;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {24'd0, rd_byte};
            end
            DATA_H: begin
                be_mask    = 4'b0011 << offset;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{rd_half[15]}}, rd_half};
                misalign   = offset[0];
            end
            DATA_HU: begin
                be_mask    = 4'b0011 << offset;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {16'd0, rd_half};
                misalign   = offset[0];
            end
            DATA_W: begin
                be_mask  = 4'b1111;
                misalign = (offset != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and load/store ports onto one byte-enabled RAM port;
// every access is a fixed IDLE -> ISSUE -> RESP sequence.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned MEM_AW       = 12,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_ack,
    output logic              i_err,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_sel,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic              d_err,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned   CntW      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

    mem_state_e        state_q, state_d;
    mem_owner_e        owner_q, owner_d;
    logic [CntW-1:0]   starve_q, starve_d;
    logic              we_q, we_d;
    logic [2:0]        sel_q, sel_d;
    logic [1:0]        off_q, off_d;
    logic              err_q, err_d;
    logic [3:0]        mem_we_q, mem_we_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic        grant_dport, grant_iport;
    logic        req_we, req_err;
    logic [2:0]  req_sel;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  fmt_sel;
    logic [1:0]  fmt_off;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_wdata, fmt_rdata, resp_rdata;
    logic        fmt_misalign;

    // D wins unless I has waited through STARVE_LIMIT consecutive D grants.
    always_comb begin
        grant_dport = d_req && (!i_req || (starve_q != StarveMax));
        grant_iport = i_req && !grant_dport;
        if (grant_dport) begin
            req_addr  = d_addr;
            req_sel   = d_sel;
            req_we    = d_we;
            req_wdata = d_wdata;
        end else begin
            req_addr  = i_addr;
            req_sel   = DATA_W;
            req_we    = 1'b0;
            req_wdata = '0;
        end
    end

    // One formatter serves both the grant (steering) and the response (extension).
    assign fmt_sel = (state_q == StIdle) ? req_sel : sel_q;
    assign fmt_off = (state_q == StIdle) ? req_addr[1:0] : off_q;

    mem_lane_fmt u_lane_fmt (
        .sel        (fmt_sel),
        .offset     (fmt_off),
        .wdata      (req_wdata),
        .rdata      (mem_rdata),
        .be_mask    (fmt_be),
        .wdata_lane (fmt_wdata),
        .rdata_ext  (fmt_rdata),
        .misalign   (fmt_misalign)
    );

    assign req_err = fmt_misalign
                   || !sel_legal(req_sel)
                   || ((req_addr >> (MEM_AW + 2)) != '0)
                   || (req_we && ((req_sel == DATA_BU) || (req_sel == DATA_HU)));

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        we_d        = we_q;
        sel_d       = sel_q;
        off_d       = off_q;
        err_d       = err_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        unique case (state_q)
            StIdle: begin
                if (grant_dport || grant_iport) begin
                    owner_d     = grant_dport ? OWN_D : OWN_I;
                    we_d        = req_we;
                    sel_d       = req_sel;
                    off_d       = req_addr[1:0];
                    err_d       = req_err;
                    mem_we_d    = (req_we && !req_err) ? fmt_be : 4'b0000;
                    mem_addr_d  = req_addr[MEM_AW+1:2];
                    mem_wdata_d = fmt_wdata;
                    if (grant_iport || !i_req) begin
                        starve_d = '0;
                    end else if (starve_q != StarveMax) begin
                        starve_d = starve_q + 1'b1;
                    end
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            owner_q     <= OWN_I;
            starve_q    <= '0;
            we_q        <= 1'b0;
            sel_q       <= DATA_B;
            off_q       <= 2'b00;
            err_q       <= 1'b0;
            mem_we_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            off_q       <= off_d;
            err_q       <= err_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        mem_en     = (state_q == StIssue) && !err_q;
        mem_we     = mem_en ? mem_we_q : 4'b0000;
        mem_addr   = (state_q == StIssue) ? mem_addr_q : '0;
        mem_wdata  = (state_q == StIssue) ? mem_wdata_q : '0;
        d_ack      = (state_q == StResp) && (owner_q == OWN_D);
        i_ack      = (state_q == StResp) && (owner_q == OWN_I);
        resp_rdata = (err_q || we_q) ? '0 : fmt_rdata;
        d_err      = d_ack && err_q;
        i_err      = i_ack && err_q;
        d_rdata    = d_ack ? resp_rdata : '0;
        i_rdata    = i_ack ? resp_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed accesses against a behavioural RAM.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    localparam int unsigned MEM_AW = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_req = 1'b0;
    logic [31:0]       i_addr = '0;
    logic              i_ack, i_err;
    logic [31:0]       i_rdata;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [2:0]        d_sel = DATA_W;
    logic [31:0]       d_addr = '0;
    logic [31:0]       d_wdata = '0;
    logic              d_ack, d_err;
    logic [31:0]       d_rdata;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = '0;

    mem_port_arbiter #(
        .MEM_AW       (MEM_AW),
        .STARVE_LIMIT (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_err     (i_err),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_sel     (d_sel),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_err     (d_err),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    resp_t exp_d[$];
    resp_t exp_i[$];

    logic [31:0] ram [0:(1<<MEM_AW)-1];

    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= ram[mem_addr];
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) ram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected response whenever an ack appears.
    always @(negedge clk) begin
        resp_t e;
        if (rst_n) begin
            if (d_ack) begin
                if (exp_d.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL d_ack_unexpected: got ack, expected none");
                end else begin
                    e = exp_d.pop_front();
                    check("d_err", 32'(d_err), 32'(e.err));
                    check("d_rdata", d_rdata, e.rdata);
                end
            end
            if (i_ack) begin
                if (exp_i.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL i_ack_unexpected: got ack, expected none");
                end else begin
                    e = exp_i.pop_front();
                    check("i_err", 32'(i_err), 32'(e.err));
                    check("i_rdata", i_rdata, e.rdata);
                end
            end
        end
    end

    task automatic d_op(input string name, input logic we, input logic [2:0] sel,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] exp_we, input logic [31:0] exp_wdata,
                        input logic exp_err, input logic [31:0] exp_rdata);
        int lat;
        @(posedge clk);
        #1;
        d_req   = 1'b1;
        d_we    = we;
        d_sel   = sel;
        d_addr  = addr;
        d_wdata = wdata;
        exp_d.push_back('{exp_err, exp_rdata});
        @(negedge clk);
        @(negedge clk);
        check({name, "/mem_en"}, 32'(mem_en), 32'(!exp_err));
        check({name, "/mem_we"}, 32'(mem_we), exp_err ? 32'd0 : 32'(exp_we));
        if (!exp_err) begin
            check({name, "/mem_addr"}, 32'(mem_addr), 32'(addr[MEM_AW+1:2]));
            if (we) check({name, "/mem_wdata"}, mem_wdata, exp_wdata);
        end
        lat = 1;
        while (!d_ack && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check({name, "/latency"}, 32'(lat), 32'd2);
        @(posedge clk);
        #1;
        d_req = 1'b0;
    endtask

    task automatic i_op(input string name, input logic [31:0] addr,
                        input logic exp_err, input logic [31:0] exp_rdata);
        int lat;
        @(posedge clk);
        #1;
        i_req  = 1'b1;
        i_addr = addr;
        exp_i.push_back('{exp_err, exp_rdata});
        @(negedge clk);
        @(negedge clk);
        check({name, "/mem_en"}, 32'(mem_en), 32'(!exp_err));
        check({name, "/mem_we"}, 32'(mem_we), 32'd0);
        if (!exp_err) check({name, "/mem_addr"}, 32'(mem_addr), 32'(addr[MEM_AW+1:2]));
        lat = 1;
        while (!i_ack && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check({name, "/latency"}, 32'(lat), 32'd2);
        @(posedge clk);
        #1;
        i_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int        k;
        int        t0;
        int        first_i;
        logic [9:0] order;

        for (int w = 0; w < (1 << MEM_AW); w++) ram[w] = '0;
        ram[4] = 32'hDEADBEEF;

        repeat (3) @(negedge clk);
        check("reset/ctrl", 32'({mem_en, mem_we, d_ack, i_ack, d_err, i_err}), 32'd0);
        check("reset/mem_addr", 32'(mem_addr), 32'd0);
        check("reset/mem_wdata", mem_wdata, 32'd0);
        check("reset/rdata", d_rdata | i_rdata, 32'd0);
        rst_n = 1'b1;

        d_op("lw_10",  1'b0, DATA_W,  32'h10, 32'h0, 4'b0000, 32'h0, 1'b0, 32'hDEADBEEF);
        d_op("sb_13",  1'b1, DATA_B,  32'h13, 32'hA5, 4'b1000, 32'hA5A5A5A5, 1'b0, 32'h0);
        d_op("lb_13",  1'b0, DATA_B,  32'h13, 32'h0, 4'b0000, 32'h0, 1'b0, 32'hFFFFFFA5);
        d_op("lbu_13", 1'b0, DATA_BU, 32'h13, 32'h0, 4'b0000, 32'h0, 1'b0, 32'h000000A5);
        d_op("lw_10b", 1'b0, DATA_W,  32'h10, 32'h0, 4'b0000, 32'h0, 1'b0, 32'hA5ADBEEF);
        d_op("sh_22",  1'b1, DATA_H,  32'h22, 32'hFFFF8001, 4'b1100, 32'h80018001, 1'b0, 32'h0);
        d_op("lh_22",  1'b0, DATA_H,  32'h22, 32'h0, 4'b0000, 32'h0, 1'b0, 32'hFFFF8001);
        d_op("lhu_22", 1'b0, DATA_HU, 32'h22, 32'h0, 4'b0000, 32'h0, 1'b0, 32'h00008001);
        d_op("lw_20",  1'b0, DATA_W,  32'h20, 32'h0, 4'b0000, 32'h0, 1'b0, 32'h80010000);
        d_op("sw_40",  1'b1, DATA_W,  32'h40, 32'h13579BDF, 4'b1111, 32'h13579BDF, 1'b0, 32'h0);
        d_op("lb_41",  1'b0, DATA_B,  32'h41, 32'h0, 4'b0000, 32'h0, 1'b0, 32'hFFFFFF9B);
        d_op("lbu_42", 1'b0, DATA_BU, 32'h42, 32'h0, 4'b0000, 32'h0, 1'b0, 32'h00000057);
        d_op("lh_40",  1'b0, DATA_H,  32'h40, 32'h0, 4'b0000, 32'h0, 1'b0, 32'hFFFF9BDF);
        d_op("lhu_42", 1'b0, DATA_HU, 32'h42, 32'h0, 4'b0000, 32'h0, 1'b0, 32'h00001357);
        i_op("if_40", 32'h40, 1'b0, 32'h13579BDF);

        d_op("lh_21_err",   1'b0, DATA_H,  32'h21, 32'h0, 4'b0000, 32'h0, 1'b1, 32'h0);
        i_op("if_02_err",   32'h02, 1'b1, 32'h0);
        d_op("lw_4000_err", 1'b0, DATA_W,  32'h4000, 32'h0, 4'b0000, 32'h0, 1'b1, 32'h0);
        d_op("sel3_err",    1'b0, 3'b011,  32'h10, 32'h0, 4'b0000, 32'h0, 1'b1, 32'h0);
        d_op("sbu_err",     1'b1, DATA_BU, 32'h10, 32'hFF, 4'b0000, 32'h0, 1'b1, 32'h0);
        d_op("sw_42_err",   1'b1, DATA_W,  32'h42, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b1, 32'h0);
        d_op("sw_4010_err", 1'b1, DATA_W,  32'h4010, 32'h0, 4'b0000, 32'h0, 1'b1, 32'h0);
        i_op("if_4000_err", 32'h4000, 1'b1, 32'h0);
        d_op("lw_10_kept",  1'b0, DATA_W,  32'h10, 32'h0, 4'b0000, 32'h0, 1'b0, 32'hA5ADBEEF);
        d_op("lw_40_kept",  1'b0, DATA_W,  32'h40, 32'h0, 4'b0000, 32'h0, 1'b0, 32'h13579BDF);

        // Both requesters held: D x4, then I, repeating.
        @(posedge clk);
        #1;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_sel  = DATA_W;
        d_addr = 32'h10;
        i_req  = 1'b1;
        i_addr = 32'h40;
        t0 = cyc;
        repeat (8) exp_d.push_back('{1'b0, 32'hA5ADBEEF});
        repeat (2) exp_i.push_back('{1'b0, 32'h13579BDF});
        k = 0;
        first_i = -1;
        order = '0;
        for (int c = 0; c < 60 && k < 10; c++) begin
            @(negedge clk);
            if (d_ack || i_ack) begin
                order[k] = i_ack;
                if (i_ack && first_i < 0) first_i = cyc - t0;
                k++;
            end
        end
        @(posedge clk);
        #1;
        d_req = 1'b0;
        i_req = 1'b0;
        check("starve/ack_count", 32'(k), 32'd10);
        check("starve/order", 32'(order), 32'h210);
        check("starve/first_i_cycle", 32'(first_i), 32'd14);

        // Reset during ISSUE of a store drops it without an ack.
        @(posedge clk);
        #1;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_sel   = DATA_W;
        d_addr  = 32'h80;
        d_wdata = 32'hCAFEF00D;
        @(negedge clk);
        @(negedge clk);
        check("rst/issue_en", 32'(mem_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst/ctrl", 32'({mem_en, mem_we, d_ack, i_ack, d_err, i_err}), 32'd0);
        check("rst/mem_addr", 32'(mem_addr), 32'd0);
        check("rst/mem_wdata", mem_wdata, 32'd0);
        d_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst/no_ack", 32'({d_ack, i_ack, mem_en}), 32'd0);
        end
        rst_n = 1'b1;
        d_op("lw_80_dropped", 1'b0, DATA_W, 32'h80, 32'h0, 4'b0000, 32'h0, 1'b0, 32'h0);
        d_op("sw_80_retry",   1'b1, DATA_W, 32'h80, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D,
             1'b0, 32'h0);
        d_op("lw_80",         1'b0, DATA_W, 32'h80, 32'h0, 4'b0000, 32'h0, 1'b0, 32'hCAFEF00D);

        repeat (4) @(negedge clk);
        check("d_queue_empty", 32'(exp_d.size()), 32'd0);
        check("i_queue_empty", 32'(exp_i.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, byte-enabled block RAM between two requesters: the core's instruction-fetch port (I) and its load/store port (D).
- Every access takes a fixed 3-cycle transaction.
- D has priority; a starvation counter bounds how long a pending I request can wait.
- Also handles byte-lane steering, read sign/zero extension, and misalignment/range errors, so the core sees plain 32-bit ports.

Parameters:
- MEM_AW, 12, RAM word-address width (RAM holds 2^MEM_AW 32-bit words).
- STARVE_LIMIT, 4, number of consecutive D grants with I pending, after which I wins the next arbitration.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held until i_ack.
- i_addr  in  32  fetch byte address (always a word access).
- i_ack  out  1  one-cycle completion pulse for I.
- i_err  out  1  valid with i_ack; misaligned or out of range.
- i_rdata  out  32  fetched word; valid with i_ack.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store.
- d_sel  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- d_addr  in  32  byte address.
- d_wdata  in  32  store data, right-aligned (B uses [7:0], H uses [15:0]).
- d_ack  out  1  one-cycle completion pulse for D.
- d_err  out  1  valid with d_ack.
- d_rdata  out  32  extended load data; valid with d_ack when the access was a load.
- mem_en  out  1  RAM access strobe.
- mem_we  out  4  per-byte write enables.
- mem_addr  out  MEM_AW  RAM word address.
- mem_wdata  out  32  lane-steered write data.
- mem_rdata  in  32  RAM read data, valid one cycle after mem_en.

Behaviour:
- Reset (asynchronous, active-low): state = IDLE; starvation counter = 0; all outputs = 0. An in-flight transaction is dropped with no ack; the requester must reissue.
- FSM states: IDLE -> ISSUE -> RESP -> IDLE. ISSUE and RESP each last exactly one cycle.
- IDLE, arbitration:
  - Only d_req: grant D.
  - Only i_req: grant I.
  - Both: grant I if counter == STARVE_LIMIT, else grant D.
  - On grant, latch owner, we, sel, addr[1:0], error flag, and pre-computed mem_* values. Go to ISSUE.
  - No request: stay in IDLE.
- Starvation counter:
  - Increments on each D grant made while i_req = 1, saturating at STARVE_LIMIT.
  - Clears on any I grant.
  - Clears on any D grant made with i_req = 0.
- ISSUE: mem_en = 1 and mem_we as latched, unless the error flag is set; then mem_en = 0 and mem_we = 0. Go to RESP.
- RESP:
  - Owner's ack = 1 and err = error flag.
  - Owner's rdata is formatted combinationally from mem_rdata using the latched sel and addr[1:0].
  - rdata = 0 on an error or a store.
  - Go to IDLE.
- Timing: request seen in IDLE at cycle N -> ack in cycle N+2. Peak throughput is one access per 3 cycles.
- Requester rules:
  - The requester deasserts req in the cycle after ack. A req still high in the first IDLE cycle is a new request.
  - Request signals are sampled only in IDLE; changes during ISSUE or RESP are ignored.
- Error conditions:
  - H/HU with addr[0] = 1.
  - W with addr[1:0] != 0.
  - I with addr[1:0] != 0.
  - sel in {011, 110, 111}.
  - addr[31:MEM_AW+2] != 0.
- Address mapping: mem_addr = addr[MEM_AW+1:2].
- Byte-lane steering for stores (o = addr[1:0]):
  - B: mem_we = 0001 << o; wdata byte replicated to all lanes.
  - H: mem_we = 0011 << o; wdata halfword replicated to both halves.
  - W: mem_we = 1111.
  - A load has mem_we = 0000.
- Load extension: select the byte or halfword at offset o. B/H sign-extend; BU/HU zero-extend; W is passed through.
- A D store with sel BU/HU is an error.

Decomposition:
- Shared package `mem_pkg`:
  - Access-type constants DATA_B = 3'b000, DATA_H = 3'b001, DATA_W = 3'b010, DATA_BU = 3'b100, DATA_HU = 3'b101 (identical to the core's encoding).
  - The FSM state enum.
  - Owner encoding OWN_I / OWN_D.
- One natural sub-module: `mem_lane_fmt`. It is purely combinational: it takes sel, offset and data, and produces mem_we, the steered wdata, the extended rdata, and the misalign flag.

Test Plan:
- D load W, addr 0x10, RAM word 4 = 0xDEADBEEF, d_req asserted at cycle 0 -> mem_en = 1 and mem_addr = 4 in cycle 1; d_ack = 1 with d_rdata = 0xDEADBEEF in cycle 2; d_err = 0.
- D store B, addr 0x13, wdata 0x000000A5 -> mem_we = 1000, mem_wdata = 0xA5A5A5A5. A following LB at 0x13 returns 0xFFFFFFA5; LBU at 0x13 returns 0x000000A5.
- d_req and i_req both held continuously, STARVE_LIMIT = 4 -> grant order D, D, D, D, I, D, D, D, D, I. I is acked no later than cycle 14 after the first request.
- LH at 0x21 and i_addr 0x02 -> ack in cycle 2 with err = 1. mem_en stays 0 throughout; RAM contents are unchanged.
- Address 0x4000 with MEM_AW = 12 -> err = 1 and no mem_en.
- rst_n low during ISSUE of a store -> all outputs 0 immediately and no ack. After release, the reissued request completes normally with latency 2.
